// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding for the shift engine
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - saturating frame bit counter with terminal-count flag
module shift_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  // terminal marks the last bit of a frame; the next increment lands on WIDTH
  assign terminal = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(WIDTH))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - framed parallel-load shift register with bit counting
module shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             parallelLoad,
  input  logic             peripheralClkEdge,
  input  logic             serialDataIn,
  input  logic [WIDTH-1:0] parallelDataIn,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bitCount
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shifted;
  logic             shift_en;
  logic             cnt_inc;
  logic             cnt_terminal;

  assign shift_en = peripheralClkEdge && !parallelLoad;
  assign cnt_inc  = shift_en && (state == SHIFT);

  assign shifted = (MSB_FIRST != 0) ? {data[WIDTH-2:0], serialDataIn}
                                    : {serialDataIn, data[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (parallelLoad) begin
      data <= parallelDataIn;
    end else if (shift_en) begin
      data <= shifted;
    end
  end

  shift_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (parallelLoad),
    .inc      (cnt_inc),
    .count    (bitCount),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (parallelLoad) begin
      state_next = SHIFT;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        SHIFT:   if (shift_en && cnt_terminal) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign parallelDataOut = data;
  assign serialDataOut   = (MSB_FIRST != 0) ? data[WIDTH-1] : data[0];
  assign busy            = (state == SHIFT);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - model-checked directed bench for shift_engine (8-bit MSB-first and 16-bit LSB-first)
module tb_shift_engine;

  typedef struct {
    logic [63:0] data;
    int          cnt;
    bit          active;
    bit          done;
  } model_t;

  logic        clk;
  logic        rst_n;

  logic        load_a, edge_a, sin_a;
  logic [7:0]  pdi_a, pdo_a;
  logic        sdo_a, busy_a, done_a;
  logic [3:0]  cnt_a;

  logic        load_b, edge_b, sin_b;
  logic [15:0] pdi_b, pdo_b;
  logic        sdo_b, busy_b, done_b;
  logic [4:0]  cnt_b;

  int     checks;
  int     errors;
  bit     started;
  model_t ma;
  model_t mb;

  shift_engine #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .parallelLoad      (load_a),
    .peripheralClkEdge (edge_a),
    .serialDataIn      (sin_a),
    .parallelDataIn    (pdi_a),
    .parallelDataOut   (pdo_a),
    .serialDataOut     (sdo_a),
    .busy              (busy_a),
    .done              (done_a),
    .bitCount          (cnt_a)
  );

  shift_engine #(.WIDTH(16), .MSB_FIRST(0)) dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .parallelLoad      (load_b),
    .peripheralClkEdge (edge_b),
    .serialDataIn      (sin_b),
    .parallelDataIn    (pdi_b),
    .parallelDataOut   (pdo_b),
    .serialDataOut     (sdo_b),
    .busy              (busy_b),
    .done              (done_b),
    .bitCount          (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t m;
    m.data = 64'd0; m.cnt = 0; m.active = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  // A frame is "active" from a load until WIDTH edges have been counted.
  function automatic model_t model_step(model_t s, int w, bit msb, bit rst, bit l, bit e,
                                        bit sin, logic [63:0] d);
    model_t m = s;
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    if (rst) return model_reset();
    m.done = 1'b0;
    if (l) begin
      m.data = d & mask; m.cnt = 0; m.active = 1'b1;
    end else if (e) begin
      if (msb) m.data = ((s.data << 1) | 64'(sin)) & mask;
      else     m.data = (s.data >> 1) | (64'(sin) << (w - 1));
      if (s.active) begin
        m.cnt = s.cnt + 1;
        if (m.cnt == w) begin
          m.active = 1'b0; m.done = 1'b1;
        end
      end
    end
    return m;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sout(model_t m, int w, bit msb);
    return msb ? m.data[w-1] : m.data[0];
  endfunction

  always @(posedge clk) begin
    #3;
    if (started) begin
      cmp("a_pdo",  64'(pdo_a),  ma.data);
      cmp("a_sdo",  64'(sdo_a),  64'(sout(ma, 8, 1'b1)));
      cmp("a_busy", 64'(busy_a), 64'(ma.active));
      cmp("a_done", 64'(done_a), 64'(ma.done));
      cmp("a_cnt",  64'(cnt_a),  64'(ma.cnt));
      cmp("b_pdo",  64'(pdo_b),  mb.data);
      cmp("b_sdo",  64'(sdo_b),  64'(sout(mb, 16, 1'b0)));
      cmp("b_busy", 64'(busy_b), 64'(mb.active));
      cmp("b_done", 64'(done_b), 64'(mb.done));
      cmp("b_cnt",  64'(cnt_b),  64'(mb.cnt));
    end
  end

  task automatic clock_models();
    @(posedge clk);
    ma = model_step(ma, 8, 1'b1, !rst_n, load_a, edge_a, sin_a, 64'(pdi_a));
    mb = model_step(mb, 16, 1'b0, !rst_n, load_b, edge_b, sin_b, 64'(pdi_b));
    #1;
  endtask

  task automatic tick_a(input bit l, input bit e, input bit s, input logic [7:0] d);
    load_a = l; edge_a = e; sin_a = s; pdi_a = d;
    load_b = 1'b0; edge_b = 1'b0; sin_b = 1'b0; pdi_b = 16'h0;
    clock_models();
  endtask

  task automatic tick_b(input bit l, input bit e, input bit s, input logic [15:0] d);
    load_b = l; edge_b = e; sin_b = s; pdi_b = d;
    load_a = 1'b0; edge_a = 1'b0; sin_a = 1'b0; pdi_a = 8'h0;
    clock_models();
  endtask

  initial begin
    checks = 0; errors = 0; started = 1'b0;
    rst_n = 1'b0;
    load_a = 0; edge_a = 0; sin_a = 0; pdi_a = 8'h0;
    load_b = 0; edge_b = 0; sin_b = 0; pdi_b = 16'h0;
    ma = model_reset(); mb = model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_pdo",  64'(pdo_a), 64'h0);
    cmp("rst_busy", 64'(busy_a), 64'h0);
    cmp("rst_done", 64'(done_a), 64'h0);
    cmp("rst_cnt",  64'(cnt_a), 64'h0);
    rst_n = 1'b1;
    started = 1'b1;

    // load then single MSB-first shift
    tick_a(1, 0, 0, 8'b10001010);
    cmp("lit_load_pdo",  64'(pdo_a), 64'h8A);
    cmp("lit_load_sdo",  64'(sdo_a), 64'h1);
    cmp("lit_load_busy", 64'(busy_a), 64'h1);
    tick_a(0, 1, 1, 8'h00);
    cmp("lit_shift_pdo", 64'(pdo_a), 64'h15);
    cmp("lit_shift_sdo", 64'(sdo_a), 64'h0);
    cmp("lit_shift_cnt", 64'(cnt_a), 64'h1);
    tick_a(0, 0, 1, 8'h00);
    cmp("lit_hold_pdo",  64'(pdo_a), 64'h15);

    // load wins over a simultaneous edge
    tick_a(1, 1, 1, 8'b00010110);
    cmp("lit_prio_pdo", 64'(pdo_a), 64'h16);
    cmp("lit_prio_cnt", 64'(cnt_a), 64'h0);

    // full frame of 8 ones
    for (int i = 0; i < 7; i++) tick_a(0, 1, 1, 8'h00);
    cmp("lit_7_done", 64'(done_a), 64'h0);
    cmp("lit_7_busy", 64'(busy_a), 64'h1);
    tick_a(0, 1, 1, 8'h00);
    cmp("lit_8_done", 64'(done_a), 64'h1);
    cmp("lit_8_cnt",  64'(cnt_a), 64'h8);
    cmp("lit_8_pdo",  64'(pdo_a), 64'hFF);
    cmp("lit_8_busy", 64'(busy_a), 64'h0);
    tick_a(0, 0, 0, 8'h00);
    cmp("lit_after_done", 64'(done_a), 64'h0);
    cmp("lit_after_busy", 64'(busy_a), 64'h0);
    tick_a(0, 1, 0, 8'h00);
    cmp("lit_9_pdo", 64'(pdo_a), 64'hFE);
    cmp("lit_9_cnt", 64'(cnt_a), 64'h8);

    // reload mid-frame restarts counting
    tick_a(1, 0, 0, 8'h5A);
    for (int i = 0; i < 5; i++) tick_a(0, 1, i[0], 8'h00);
    cmp("lit_mid_cnt5", 64'(cnt_a), 64'h5);
    tick_a(1, 0, 0, 8'h3C);
    cmp("lit_reload_cnt",  64'(cnt_a), 64'h0);
    cmp("lit_reload_busy", 64'(busy_a), 64'h1);
    for (int i = 0; i < 7; i++) tick_a(0, 1, 1'b0, 8'h00);
    cmp("lit_reload_7done", 64'(done_a), 64'h0);
    tick_a(0, 1, 1'b1, 8'h00);
    cmp("lit_reload_8done", 64'(done_a), 64'h1);
    cmp("lit_reload_8pdo",  64'(pdo_a), 64'h01);

    // load while DONE goes straight back to SHIFT
    tick_a(1, 0, 0, 8'hC3);
    cmp("lit_done_reload_busy", 64'(busy_a), 64'h1);

    // asynchronous reset three shifts into a frame
    for (int i = 0; i < 3; i++) tick_a(0, 1, 1, 8'h00);
    rst_n = 1'b0;
    ma = model_reset(); mb = model_reset();
    #1;
    cmp("lit_arst_pdo",  64'(pdo_a), 64'h0);
    cmp("lit_arst_cnt",  64'(cnt_a), 64'h0);
    cmp("lit_arst_busy", 64'(busy_a), 64'h0);
    cmp("lit_arst_done", 64'(done_a), 64'h0);
    tick_a(1, 0, 0, 8'hAA);
    cmp("lit_in_rst_pdo", 64'(pdo_a), 64'h0);
    rst_n = 1'b1;
    tick_a(1, 0, 0, 8'h81);
    cmp("lit_post_rst_pdo", 64'(pdo_a), 64'h81);

    // 16-bit LSB-first instance
    tick_b(1, 0, 0, 16'h8001);
    cmp("lit_b_load_sdo", 64'(sdo_b), 64'h1);
    tick_b(0, 1, 0, 16'h0000);
    cmp("lit_b_shift_pdo", 64'(pdo_b), 64'h4000);
    cmp("lit_b_shift_sdo", 64'(sdo_b), 64'h0);
    for (int i = 0; i < 15; i++) tick_b(0, 1, i[1], 16'h0000);
    cmp("lit_b_done", 64'(done_b), 64'h1);
    cmp("lit_b_cnt",  64'(cnt_b), 64'd16);
    tick_b(0, 1, 1, 16'h0000);
    cmp("lit_b_sat_cnt", 64'(cnt_b), 64'd16);
    repeat (2) tick_b(0, 0, 0, 16'h0000);

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
